// File: rtl/time_set_ctrl.sv
// Time-setting controller for the HH:MM:SS clock: gates the 1 Hz tick, edits hours/minutes, issues a one-shot load.
// Optional build macro AUTO_REPEAT_EN adds press-and-hold auto-repeat on btn_inc.
module time_set_ctrl #(
    parameter int TIMEOUT_S     = 30,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 12_500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [1:0] cur_h_msd,
    input  logic [3:0] cur_h_lsd,
    input  logic [2:0] cur_m_msd,
    input  logic [3:0] cur_m_lsd,
    output logic       tick_out,
    output logic       load,
    output logic [1:0] ld_h_msd,
    output logic [3:0] ld_h_lsd,
    output logic [2:0] ld_m_msd,
    output logic [3:0] ld_m_lsd,
    output logic       blank_h,
    output logic       blank_m,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {RUN = 2'b00, SET_H = 2'b01, SET_M = 2'b10, COMMIT = 2'b11} state_t;

    localparam int TMO_W = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;

    state_t             state_q, state_d;
    logic [1:0]         mode_sync_q, mode_sync_d, inc_sync_q, inc_sync_d;
    logic               mode_prev_q, mode_prev_d, inc_prev_q, inc_prev_d;
    logic               phase_q, phase_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [1:0]         eh_msd_q, eh_msd_d, nh_msd;
    logic [3:0]         eh_lsd_q, eh_lsd_d, nh_lsd;
    logic [2:0]         em_msd_q, em_msd_d, nm_msd;
    logic [3:0]         em_lsd_q, em_lsd_d, nm_lsd;
    logic               mode_press, inc_press, repeat_fire, editing;

    assign mode_press = mode_sync_q[1] & ~mode_prev_q;
    assign inc_press  = inc_sync_q[1] & ~inc_prev_q;
    assign editing    = (state_q == SET_H) || (state_q == SET_M);

    // BCD successors of the edit registers; out-of-range values wrap to 00
    always_comb begin
        nh_msd = eh_msd_q;
        nh_lsd = eh_lsd_q + 4'd1;
        if (eh_msd_q >= 2'd2 && eh_lsd_q >= 4'd3) begin
            nh_msd = 2'd0;
            nh_lsd = 4'd0;
        end else if (eh_lsd_q >= 4'd9) begin
            nh_msd = eh_msd_q + 2'd1;
            nh_lsd = 4'd0;
        end
    end

    always_comb begin
        nm_msd = em_msd_q;
        nm_lsd = em_lsd_q + 4'd1;
        if (em_lsd_q >= 4'd9) begin
            nm_lsd = 4'd0;
            nm_msd = (em_msd_q >= 3'd5) ? 3'd0 : em_msd_q + 3'd1;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rep_q, rep_d;

    // First repeat after HOLD_CYCLES, then every REPEAT_CYCLES while still held
    always_comb begin
        hold_d      = hold_q;
        rep_d       = rep_q;
        repeat_fire = 1'b0;
        if (!editing || !inc_sync_q[1] || mode_press || inc_press) begin
            hold_d = '0;
            rep_d  = 1'b0;
        end else if (hold_q == HOLD_W'(rep_q ? REPEAT_CYCLES - 1 : HOLD_CYCLES - 1)) begin
            repeat_fire = 1'b1;
            hold_d      = '0;
            rep_d       = 1'b1;
        end else begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end
`else
    // Constant 0; the repeat timing parameters only matter when auto-repeat is built in
    assign repeat_fire = (HOLD_CYCLES < 0) && (REPEAT_CYCLES < 0);
`endif

    always_comb begin
        state_d     = state_q;
        mode_sync_d = {mode_sync_q[0], btn_mode};
        inc_sync_d  = {inc_sync_q[0], btn_inc};
        mode_prev_d = mode_sync_q[1];
        inc_prev_d  = inc_sync_q[1];
        phase_d     = enable1hz ? ~phase_q : phase_q;
        tmo_d       = tmo_q;
        eh_msd_d    = eh_msd_q;
        eh_lsd_d    = eh_lsd_q;
        em_msd_d    = em_msd_q;
        em_lsd_d    = em_lsd_q;
        case (state_q)
            RUN: begin
                tmo_d = '0;
                if (mode_press) begin
                    state_d  = SET_H;
                    phase_d  = 1'b0;
                    eh_msd_d = cur_h_msd;
                    eh_lsd_d = cur_h_lsd;
                    em_msd_d = cur_m_msd;
                    em_lsd_d = cur_m_lsd;
                end
            end
            SET_H, SET_M: begin
                if (mode_press) begin
                    state_d = (state_q == SET_H) ? SET_M : COMMIT;
                    phase_d = 1'b0;
                    tmo_d   = '0;
                end else if (inc_press || repeat_fire) begin
                    tmo_d = '0;
                    if (state_q == SET_H) begin
                        eh_msd_d = nh_msd;
                        eh_lsd_d = nh_lsd;
                    end else begin
                        em_msd_d = nm_msd;
                        em_lsd_d = nm_lsd;
                    end
                end else if (enable1hz && TIMEOUT_S != 0) begin
                    if (tmo_q == TMO_W'(TIMEOUT_S - 1)) begin
                        state_d = RUN;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            mode_sync_q <= '0;
            inc_sync_q  <= '0;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            phase_q     <= 1'b0;
            tmo_q       <= '0;
            eh_msd_q    <= '0;
            eh_lsd_q    <= '0;
            em_msd_q    <= '0;
            em_lsd_q    <= '0;
        end else begin
            state_q     <= state_d;
            mode_sync_q <= mode_sync_d;
            inc_sync_q  <= inc_sync_d;
            mode_prev_q <= mode_prev_d;
            inc_prev_q  <= inc_prev_d;
            phase_q     <= phase_d;
            tmo_q       <= tmo_d;
            eh_msd_q    <= eh_msd_d;
            eh_lsd_q    <= eh_lsd_d;
            em_msd_q    <= em_msd_d;
            em_lsd_q    <= em_lsd_d;
        end
    end

    assign tick_out = enable1hz & (state_q == RUN);
    assign load     = (state_q == COMMIT);
    assign mode     = state_q;
    assign blank_h  = (state_q == SET_H) & phase_q;
    assign blank_m  = (state_q == SET_M) & phase_q;
    assign ld_h_msd = eh_msd_q;
    assign ld_h_lsd = eh_lsd_q;
    assign ld_m_msd = em_msd_q;
    assign ld_m_lsd = em_lsd_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: edit sequences, wraps, timeout, blink, reset and hold behaviour.
module tb_time_set_ctrl;

    logic       clock = 1'b0, reset = 1'b1, enable1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [1:0] cur_h_msd = 2'd1;
    logic [3:0] cur_h_lsd = 4'd3;
    logic [2:0] cur_m_msd = 3'd4;
    logic [3:0] cur_m_lsd = 4'd7;
    logic       tick_out, load, blank_h, blank_m;
    logic [1:0] ld_h_msd, mode;
    logic [3:0] ld_h_lsd, ld_m_lsd;
    logic [2:0] ld_m_msd;

    int         checks = 0, errors = 0, tick_cnt = 0, load_cnt = 0, lc, tc;
    logic [15:0] last_ld = 16'hffff;

    wire [7:0] ld_hour = {2'b00, ld_h_msd, ld_h_lsd};
    wire [7:0] ld_min  = {1'b0, ld_m_msd, ld_m_lsd};

`ifdef AUTO_REPEAT_EN
    localparam logic [7:0] HOLD_H13 = 8'h02, HOLD_END = 8'h05;
`else
    localparam logic [7:0] HOLD_H13 = 8'h01, HOLD_END = 8'h01;
`endif

    time_set_ctrl #(.TIMEOUT_S(3), .HOLD_CYCLES(10), .REPEAT_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .enable1hz(enable1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_h_msd(cur_h_msd), .cur_h_lsd(cur_h_lsd), .cur_m_msd(cur_m_msd), .cur_m_lsd(cur_m_lsd),
        .tick_out(tick_out), .load(load), .ld_h_msd(ld_h_msd), .ld_h_lsd(ld_h_lsd),
        .ld_m_msd(ld_m_msd), .ld_m_lsd(ld_m_lsd), .blank_h(blank_h), .blank_m(blank_m), .mode(mode)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (tick_out) tick_cnt++;
        if (load) begin
            load_cnt++;
            last_ld = {ld_hour, ld_min};
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        step(3);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step(3);
    endtask

    task automatic pulse();
        enable1hz = 1'b1;
        step(1);
        enable1hz = 1'b0;
    endtask

    task automatic do_commit(input logic [15:0] exp_ld);
        lc = load_cnt;
        btn_mode = 1'b1;
        step(3);
        check_val("commit_mode", mode, 2'b11);
        check_val("commit_load", load, 1'b1);
        check_val("commit_ld", {ld_hour, ld_min}, exp_ld);
        step(1);
        check_val("after_commit_mode", mode, 2'b00);
        check_val("after_commit_load", load, 1'b0);
        btn_mode = 1'b0;
        step(3);
        check_val("load_pulses", load_cnt - lc, 1);
        check_val("loaded_value", last_ld, exp_ld);
    endtask

    initial begin
        step(2);
        check_val("rst_mode", mode, 2'b00);
        check_val("rst_load", load, 1'b0);
        check_val("rst_blank", {blank_h, blank_m}, 2'b00);
        check_val("rst_ld", {ld_hour, ld_min}, 16'h0000);
        check_val("rst_tick", tick_out, 1'b0);
        reset = 1'b0;
        step(2);

        // 13:47 -> 00:00 through both wraps
        press(1'b1, 1'b0);
        check_val("seth_mode", mode, 2'b01);
        check_val("seth_copy", {ld_hour, ld_min}, 16'h1347);
        check_val("seth_blank", blank_h, 1'b0);
        press(1'b0, 1'b1);
        check_val("hour_14", ld_hour, 8'h14);
        repeat (10) press(1'b0, 1'b1);
        check_val("hour_wrap", ld_hour, 8'h00);
        enable1hz = 1'b1;
        #1;
        check_val("tick_gated_seth", tick_out, 1'b0);
        step(1);
        enable1hz = 1'b0;
        check_val("blink_on", blank_h, 1'b1);
        press(1'b1, 1'b0);
        check_val("setm_mode", mode, 2'b10);
        check_val("setm_blank", {blank_h, blank_m}, 2'b00);
        repeat (13) press(1'b0, 1'b1);
        check_val("min_wrap", {ld_hour, ld_min}, 16'h0000);
        enable1hz = 1'b1;
        #1;
        check_val("tick_gated_setm", tick_out, 1'b0);
        step(1);
        enable1hz = 1'b0;
        do_commit(16'h0000);

        // 08:09 -> 10:10 carries
        cur_h_msd = 2'd0; cur_h_lsd = 4'd8; cur_m_msd = 3'd0; cur_m_lsd = 4'd9;
        press(1'b1, 1'b0);
        check_val("copy_0809", {ld_hour, ld_min}, 16'h0809);
        press(1'b0, 1'b1);
        check_val("hour_09", ld_hour, 8'h09);
        press(1'b0, 1'b1);
        check_val("hour_carry", ld_hour, 8'h10);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check_val("min_carry", ld_min, 8'h10);
        do_commit(16'h1010);

        // timeout in SET_M after 3 ticks
        lc = load_cnt;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        pulse();
        pulse();
        check_val("tmo_not_yet", mode, 2'b10);
        pulse();
        check_val("tmo_abort", mode, 2'b00);
        step(3);
        check_val("tmo_no_load", load_cnt - lc, 0);

        // simultaneous mode+inc, then blink sequence
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        check_val("both_mode", mode, 2'b10);
        check_val("both_hour", {ld_hour, ld_min}, 16'h0809);
        do_commit(16'h0809);
        press(1'b1, 1'b0);
        check_val("blink0", {blank_h, blank_m}, 2'b00);
        pulse();
        check_val("blink1", {blank_h, blank_m}, 2'b10);
        pulse();
        check_val("blink2", {blank_h, blank_m}, 2'b00);
        press(1'b0, 1'b1);
        check_val("blink_inc_hour", ld_hour, 8'h09);
        pulse();
        check_val("blink3", {blank_h, blank_m}, 2'b10);
        press(1'b1, 1'b0);
        check_val("setm_entry_blank", {blank_h, blank_m}, 2'b00);
        pulse();
        check_val("blink_m", {blank_h, blank_m}, 2'b01);

        // async reset mid-edit
        lc = load_cnt;
        #2;
        reset = 1'b1;
        #1;
        check_val("async_mode", mode, 2'b00);
        check_val("async_blank", {blank_h, blank_m}, 2'b00);
        check_val("async_ld", {ld_hour, ld_min}, 16'h0000);
        check_val("async_load", load, 1'b0);
        step(1);
        reset = 1'b0;
        tc = tick_cnt;
        repeat (10) begin
            pulse();
            step(1);
        end
        check_val("ten_ticks", tick_cnt - tc, 10);
        check_val("rst_no_load", load_cnt - lc, 0);

        // tick on the RUN->SET_H edge still passes
        cur_h_msd = 2'd0; cur_h_lsd = 4'd0; cur_m_msd = 3'd0; cur_m_lsd = 4'd0;
        tc = tick_cnt;
        btn_mode = 1'b1;
        step(2);
        enable1hz = 1'b1;
        #1;
        check_val("entry_tick", tick_out, 1'b1);
        step(1);
        enable1hz = 1'b0;
        check_val("entry_mode", mode, 2'b01);
        check_val("entry_tick_cnt", tick_cnt - tc, 1);
        check_val("entry_phase", blank_h, 1'b0);
        btn_mode = 1'b0;
        step(3);

        // hold inc for 25 clocks from the rise
        btn_inc = 1'b1;
        step(12);
        check_val("hold_press9", ld_hour, 8'h01);
        step(1);
        check_val("hold_press10", ld_hour, HOLD_H13);
        step(12);
        btn_inc = 1'b0;
        step(5);
        check_val("hold_total", ld_hour, HOLD_END);
        check_val("hold_mode", mode, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
